nf10_tx_port_arbiter: RTL

- Packet-granular round-robin arbiter sharing one 10G interface TX AXI-Stream slave (s_axis, 256-bit data, 128-bit tuser) among C_NUM_INPUTS upstream requesters, e.g. DMA queues and the output port lookup.
- Sits directly in front of the 10G interface TX port in the reference NIC.
- Holds a grant for a whole packet, from first beat to tlast. Never interleaves beats of different packets.

---
 rtl/nf10_tx_port_arbiter_if.sv | 27 ++
 rtl/nf10_tx_port_arbiter.sv | 73 +++++++
 2 files changed

// File: rtl/nf10_tx_port_arbiter_if.sv
// nf10_tx_port_arbiter_if: flattened multi-input AXI-Stream bundle plus the single shared output stream.
interface nf10_tx_port_arbiter_if #(
  parameter int C_NUM_INPUTS = 4,
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
);
  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata;
  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
  logic [C_NUM_INPUTS-1:0] s_axis_tvalid;
  logic [C_NUM_INPUTS-1:0] s_axis_tlast;
  logic [C_NUM_INPUTS-1:0] s_axis_tready;
  logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;
  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    input s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/nf10_tx_port_arbiter.sv
// nf10_tx_port_arbiter: packet-granular round-robin arbiter feeding one 10G TX stream; NF10_ARB_DST_STAMP_EN stamps C_DST_PORT into tuser[31:24] on first beats.
module nf10_tx_port_arbiter #(
  parameter int C_NUM_INPUTS = 4,
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_DST_PORT = 8'h01
) (
  input logic axi_aclk,
  input logic axi_reset,
  nf10_tx_port_arbiter_if.slave axis,
  output logic [2:0] grant_idx,
  output logic busy
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH/8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT = 1'b1;
  logic [0:0] state;
  logic [2:0] last_served;
  logic [2:0] pick;
  logic first_beat;
  logic beat_done;
  assign busy = state == PKT;
  assign beat_done = axis.m_axis_tvalid & axis.m_axis_tready;
  // descending distance so the nearest requester after last_served wins
  always_comb begin
    pick = last_served;
    for (int k = C_NUM_INPUTS; k >= 1; k--)
      for (int i = 0; i < C_NUM_INPUTS; i++)
        if (i == (int'(last_served) + k) % C_NUM_INPUTS && axis.s_axis_tvalid[i]) pick = 3'(i);
  end
  always_comb begin
    axis.m_axis_tdata = '0;
    axis.m_axis_tstrb = '0;
    axis.m_axis_tuser = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast = 1'b0;
    axis.s_axis_tready = '0;
    for (int i = 0; i < C_NUM_INPUTS; i++)
      if (grant_idx == 3'(i)) begin
        axis.m_axis_tdata = axis.s_axis_tdata[i*DW +: DW];
        axis.m_axis_tstrb = axis.s_axis_tstrb[i*SW +: SW];
        axis.m_axis_tuser = axis.s_axis_tuser[i*UW +: UW];
        axis.m_axis_tvalid = busy & axis.s_axis_tvalid[i];
        axis.m_axis_tlast = busy & axis.s_axis_tlast[i];
        axis.s_axis_tready[i] = busy & axis.m_axis_tready;
      end
    if (first_beat) axis.m_axis_tuser[31:24] = C_DST_PORT;
  end
  always_ff @(posedge axi_aclk)
    if (axi_reset) begin
      state <= IDLE;
      grant_idx <= '0;
      last_served <= 3'(C_NUM_INPUTS - 1);
    end else if (state == IDLE) begin
      if (|axis.s_axis_tvalid) begin
        grant_idx <= pick;
        state <= PKT;
      end
    end else if (beat_done && axis.m_axis_tlast) begin
      last_served <= grant_idx;
      state <= IDLE;
    end
`ifdef NF10_ARB_DST_STAMP_EN
  always_ff @(posedge axi_aclk)
    if (axi_reset) first_beat <= 1'b0;
    else if (state == IDLE) first_beat <= 1'b1;
    else if (beat_done) first_beat <= 1'b0;
`else
  assign first_beat = 1'b0;
`endif
endmodule
